// File: rtl/uart_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_sample_rx
// Purpose  : Oversampling UART receiver that assembles multi-byte samples,
//            tags them with a round-robin channel index and queues them in a
//            show-ahead FIFO. Define UART_PARITY_EN for 8E1 framing.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sample_rx #(
    parameter int CLK_FREQ     = 12_000_000,
    parameter int BAUD         = 230_400,
    parameter int SAMPLE_BYTES = 2,
    parameter int NUM_CHANNELS = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int TIMEOUT_BITS = 20,
    localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int SW          = 8 * SAMPLE_BYTES
) (
    input  logic            CLK_IN,
    input  logic            RST_N_i,
    input  logic            UART_RX_i,
    output logic [SW-1:0]   SAMPLE_o,
    output logic [CH_W-1:0] CHANNEL_o,
    output logic            VALID_o,
    input  logic            READY_i,
    output logic            FRAME_ERR_o,
    output logic            OVERFLOW_o
);

    localparam int C_BIT_PERIOD = CLK_FREQ / BAUD;
    localparam int C_HALF       = C_BIT_PERIOD / 2;
    localparam int C_CNT_W      = $clog2(C_BIT_PERIOD);
    localparam int C_TO_CYCLES  = TIMEOUT_BITS * C_BIT_PERIOD;
    localparam int C_TO_W       = $clog2(C_TO_CYCLES + 1);
    localparam int C_BI_W       = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int C_AW         = $clog2(FIFO_DEPTH);
    localparam int C_EW         = CH_W + SW;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;
`endif

    logic [1:0]         r_sync;
    logic               w_rx;
    state_t             r_state;
    state_t             w_state_next;
    logic [C_CNT_W-1:0] r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_tick;
    logic               w_byte_done;
    logic               w_frame_err;
    logic               w_timeout;
    logic               w_last;
    logic [C_TO_W-1:0]  r_idle_cnt;
    logic [C_BI_W-1:0]  r_byte_idx;
    logic [CH_W-1:0]    r_ch;
    logic [SW-1:0]      r_sample;
    logic [SW-1:0]      w_sample_asm;
    logic               r_push;
    logic [C_EW-1:0]    r_push_data;
    logic               r_frame_err;
    logic               r_overflow;
    logic [C_EW-1:0]    r_mem [FIFO_DEPTH];
    logic [C_AW-1:0]    r_wr_ptr;
    logic [C_AW-1:0]    r_rd_ptr;
    logic [C_AW:0]      r_count;
    logic               w_full;
    logic               w_valid;
    logic               w_pop;
    logic               w_wr;
    logic [C_EW-1:0]    w_head;

    // Two-flop synchroniser, preset high so reset never looks like a start bit
    always_ff @(posedge CLK_IN or negedge RST_N_i) begin
        if (!RST_N_i) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], UART_RX_i};
    end
    assign w_rx   = r_sync[1];
    assign w_tick = (r_bit_cnt == '0);

    always_ff @(posedge CLK_IN or negedge RST_N_i) begin
        if (!RST_N_i) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_byte_done  = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            S_IDLE:      if (!w_rx) w_state_next = S_START;
            S_START:     if (w_tick) w_state_next = w_rx ? S_IDLE : S_DATA;
            S_DATA: begin
                if (w_tick && r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (w_tick) begin
                    if ((^r_shift) != w_rx) begin
                        w_frame_err  = 1'b1;
                        w_state_next = w_rx ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        w_state_next = S_STOP;
                    end
                end
            end
`endif
            S_STOP: begin
                if (w_tick) begin
                    if (w_rx) begin
                        w_byte_done  = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: if (w_rx) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // Bit timer preloads half a period while idle so START samples mid-bit
    always_ff @(posedge CLK_IN or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == S_IDLE || r_state == S_WAIT_HIGH)
                r_bit_cnt <= C_CNT_W'(C_HALF - 1);
            else if (w_tick)
                r_bit_cnt <= C_CNT_W'(C_BIT_PERIOD - 1);
            else
                r_bit_cnt <= r_bit_cnt - 1'b1;

            if (r_state != S_DATA) r_bit_idx <= '0;
            else if (w_tick)       r_bit_idx <= r_bit_idx + 1'b1;

            if (r_state == S_DATA && w_tick) r_shift <= {w_rx, r_shift[7:1]};
        end
    end

    assign w_last    = (r_byte_idx == C_BI_W'(SAMPLE_BYTES - 1));
    assign w_timeout = (r_state == S_IDLE) && (r_byte_idx != '0) && w_rx &&
                       (r_idle_cnt == C_TO_W'(C_TO_CYCLES - 1));

    always_comb begin
        w_sample_asm = r_sample;
        w_sample_asm[int'(r_byte_idx) * 8 +: 8] = r_shift;
    end

    always_ff @(posedge CLK_IN or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_idle_cnt  <= '0;
            r_byte_idx  <= '0;
            r_ch        <= '0;
            r_sample    <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE && r_byte_idx != '0 && w_rx && !w_timeout)
                r_idle_cnt <= r_idle_cnt + 1'b1;
            else
                r_idle_cnt <= '0;

            if (w_frame_err || w_timeout) begin
                r_byte_idx <= '0;
                r_ch       <= '0;
                r_sample   <= '0;
            end else if (w_byte_done) begin
                if (w_last) begin
                    r_byte_idx <= '0;
                    r_sample   <= '0;
                    r_ch       <= (r_ch == CH_W'(NUM_CHANNELS - 1)) ? '0 : r_ch + 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 1'b1;
                    r_sample   <= w_sample_asm;
                end
            end

            r_push      <= w_byte_done && w_last;
            r_push_data <= {r_ch, w_sample_asm};
            r_frame_err <= w_frame_err;
        end
    end

    assign w_full  = (r_count == (C_AW + 1)'(FIFO_DEPTH));
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && READY_i;
    assign w_wr    = r_push && (!w_full || w_pop);

    always_ff @(posedge CLK_IN) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
    end

    always_ff @(posedge CLK_IN or negedge RST_N_i) begin
        if (!RST_N_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow <= r_push && w_full && !w_pop;
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign SAMPLE_o    = w_valid ? w_head[SW-1:0] : '0;
    assign CHANNEL_o   = w_valid ? w_head[C_EW-1:SW] : '0;
    assign VALID_o     = w_valid;
    assign FRAME_ERR_o = r_frame_err;
    assign OVERFLOW_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_sample_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sample_rx
// Purpose  : Self-checking bench for uart_sample_rx with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sample_rx;

    localparam int CLK_FREQ = 12_000_000;
    localparam int BAUD     = 230_400;
    localparam int SB       = 2;
    localparam int NCH      = 2;
    localparam int DEPTH    = 4;
    localparam int TO_BITS  = 20;
    localparam int BIT      = CLK_FREQ / BAUD;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        ready = 1'b1;
    logic [15:0] sample;
    logic [0:0]  channel;
    logic        valid;
    logic        frame_err;
    logic        overflow;

    uart_sample_rx #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SAMPLE_BYTES(SB),
        .NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH), .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .CLK_IN(clk), .RST_N_i(rst_n), .UART_RX_i(rx),
        .SAMPLE_o(sample), .CHANNEL_o(channel), .VALID_o(valid),
        .READY_i(ready), .FRAME_ERR_o(frame_err), .OVERFLOW_o(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int ferr_seen = 0, ferr_exp = 0;
    int ovf_seen = 0, ovf_exp = 0;

    // Reference model: bytes accumulate LSB-first into a sample; completed
    // samples enter a bounded queue standing in for the output FIFO.
    int          m_idx = 0;
    int          m_ch  = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] exp_s[$];
    logic [31:0] exp_c[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        m_idx = 0;
        m_ch  = 0;
        m_acc = '0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            ferr_exp++;
            model_clear();
            return;
        end
        m_acc = m_acc | (32'(b) << (8 * m_idx));
        m_idx++;
        if (m_idx == SB) begin
            if (exp_s.size() >= DEPTH) begin
                ovf_exp++;
            end else begin
                exp_s.push_back(m_acc);
                exp_c.push_back(32'(m_ch));
            end
            m_idx = 0;
            m_acc = '0;
            m_ch  = (m_ch + 1) % NCH;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_seen++;
            if (overflow)  ovf_seen++;
            if (valid) begin
                if (exp_s.size() == 0) begin
                    check_val("unexpected_valid", 32'(valid), 32'd0);
                end else if (ready) begin
                    check_val("sample", 32'(sample), exp_s[0]);
                    check_val("channel", 32'(channel), exp_c[0]);
                    void'(exp_s.pop_front());
                    void'(exp_c.pop_front());
                    pop_cyc = cyc;
                end else begin
                    check_val("held_sample", 32'(sample), exp_s[0]);
                end
            end
        end
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_PARITY_EN
        drive_bit((^b) ^ bad_par);
`endif
        rx = !bad_stop;
        model_byte(b, !(bad_stop || bad_par));
        repeat (BIT) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int bits);
        rx = 1'b1;
        repeat (bits * BIT) @(posedge clk);
        #1;
        if (bits >= TO_BITS && m_idx != 0) model_clear();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_s.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val(tag, 32'(exp_s.size()), 32'd0);
    endtask

    task automatic reset_checks(input string tag);
        @(negedge clk);
        check_val({tag, "_sample"}, 32'(sample), 32'd0);
        check_val({tag, "_channel"}, 32'(channel), 32'd0);
        check_val({tag, "_valid"}, 32'(valid), 32'd0);
        check_val({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_start;
        int lat;
        int ovf_before;

        rst_n = 1'b0;
        reset_checks("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_bits(2);

        // Single sample and its latency from the start bit of the last byte
        send_byte(8'h00, 1'b0, 1'b0);
        idle_bits(1);
        t_start = cyc;
        send_byte(8'h40, 1'b0, 1'b0);
        idle_bits(2);
        lat = pop_cyc - t_start;
        check_val("latency_window",
                  32'(lat >= (19 * BIT) / 2 + PAR * BIT && lat <= (19 * BIT) / 2 + PAR * BIT + 6), 32'd1);
        drain("drain_first");

        // Channel interleave
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h61, 1'b0, 1'b0);
        idle_bits(1);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h90, 1'b0, 1'b0);
        idle_bits(2);
        drain("drain_channels");

        // Framing error resynchronises to byte 0, channel 0
        send_byte(8'h55, 1'b0, 1'b0);
        idle_bits(1);
        send_byte(8'h29, 1'b1, 1'b0);
        idle_bits(2);
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h40, 1'b0, 1'b0);
        idle_bits(2);
        drain("drain_frame");
        check_val("ferr_count_directed", 32'(ferr_seen), 32'(ferr_exp));

        // Inter-byte timeout drops the partial sample
        send_byte(8'h77, 1'b0, 1'b0);
        idle_bits(25);
        send_byte(8'h19, 1'b0, 1'b0);
        send_byte(8'h91, 1'b0, 1'b0);
        idle_bits(2);
        drain("drain_timeout");

        // Overflow with a stalled consumer
        ready = 1'b0;
        ovf_before = ovf_seen;
        for (int k = 1; k <= 5; k++) begin
            send_byte(8'(k), 1'b0, 1'b0);
            send_byte(8'h00, 1'b0, 1'b0);
            idle_bits(1);
        end
        check_val("ovf_pulses", 32'(ovf_seen - ovf_before), 32'd1);
        check_val("full_valid", 32'(valid), 32'd1);
        check_val("full_head", 32'(sample), 32'd1);
        ready = 1'b1;
        drain("drain_overflow");
        @(negedge clk);
        check_val("empty_after_drain", 32'(valid), 32'd0);

        // Asynchronous reset mid-byte with a queued sample and a partial sample
        ready = 1'b0;
        send_byte(8'h21, 1'b0, 1'b0);
        send_byte(8'h43, 1'b0, 1'b0);
        idle_bits(1);
        send_byte(8'h11, 1'b0, 1'b0);
        idle_bits(1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_s.delete();
        exp_c.delete();
        model_clear();
        for (int i = 0; i < 3; i++) reset_checks("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready = 1'b1;
        idle_bits(2);
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h40, 1'b0, 1'b0);
        idle_bits(2);
        drain("drain_reset");

`ifdef UART_PARITY_EN
        send_byte(8'h03, 1'b0, 1'b1);
        idle_bits(2);
        send_byte(8'h03, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        idle_bits(2);
        drain("drain_parity");
`endif

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            bit bad_stop;
            bit bad_par;
            int gap;
            b        = 8'($urandom);
            bad_stop = ($urandom_range(0, 9) == 0);
            bad_par  = (PAR != 0) && ($urandom_range(0, 9) == 0);
            ready    = 1'($urandom_range(0, 1));
            gap      = ($urandom_range(0, 19) == 0) ? 25 : int'($urandom_range(1, 3));
            send_byte(b, bad_stop, bad_par);
            idle_bits(gap);
        end
        ready = 1'b1;
        idle_bits(2);
        drain("drain_random");

        @(negedge clk);
        check_val("final_valid", 32'(valid), 32'd0);
        check_val("ferr_count", 32'(ferr_seen), 32'(ferr_exp));
        check_val("ovf_count", 32'(ovf_seen), 32'(ovf_exp));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_sample_rx.md
Name: uart_sample_rx

Overview:
- Parametrised UART sample receiver for the DAC board family, replacing the fixed single-channel, 2-byte receive path.
- Oversamples UART_RX_i and assembles SAMPLE_BYTES bytes per sample, LSB byte first.
- Tags each sample with a round-robin channel index and buffers it in a show-ahead FIFO with a valid/ready output.
- Adds framing-error and inter-byte-timeout resynchronisation that the previous generation lacked.

Parameters:
- CLK_FREQ, 12_000_000: system clock in Hz.
- BAUD, 230_400: UART bit rate. Bit period is CLK_FREQ/BAUD, integer-truncated (52 at the defaults).
- SAMPLE_BYTES, 2: bytes per sample, range 1..4. Sample width is 8*SAMPLE_BYTES.
- NUM_CHANNELS, 1: channels interleaved on the link, range 1..8. CH_W is clog2(NUM_CHANNELS), minimum 1.
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.
- TIMEOUT_BITS, 20: idle bit periods that abort a partial sample.

Ports:
- CLK_IN, input, 1: system clock.
- RST_N_i, input, 1: asynchronous active-low reset.
- UART_RX_i, input, 1: asynchronous serial line, idles high.
- SAMPLE_o, output, 8*SAMPLE_BYTES: FIFO head sample.
- CHANNEL_o, output, CH_W: FIFO head channel index.
- VALID_o, output, 1: FIFO non-empty.
- READY_i, input, 1: consumer accepts the head entry.
- FRAME_ERR_o, output, 1: one-cycle pulse on a framing error.
- OVERFLOW_o, output, 1: one-cycle pulse when a completed sample is dropped.

Behaviour:
- Reset, asserted asynchronously:
  - SAMPLE_o=0, CHANNEL_o=0, VALID_o=0, FRAME_ERR_o=0, OVERFLOW_o=0.
  - FIFO empty, byte index=0, channel=0, RX FSM in IDLE.
  - Synchroniser flops preset to 1.
  - Reset mid-byte discards all partial data. After release, nothing is received until a new falling edge.
- Input sync: UART_RX_i passes through 2 flops; all logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on sync line = 0, go to START and load the bit counter with half a bit period.
  - START: at half-bit, line = 1 is a glitch, return to IDLE with no error. Line = 0 goes to DATA.
  - DATA: 8 samples at bit centres (one full period apart), LSB first, then STOP.
  - STOP: centre sample = 1 means the byte is good and returns to IDLE. Centre sample = 0 is a framing error:
    - pulse FRAME_ERR_o;
    - clear the byte index and channel to 0 and discard the partial sample;
    - go to WAIT_HIGH.
  - WAIT_HIGH: stays until the sync line = 1, then IDLE.
- Assembly:
  - Byte k (0-based) lands in sample bits [8k+7:8k].
  - When byte index reaches SAMPLE_BYTES-1 and the byte is good:
    - push {channel, sample} to the FIFO;
    - reset the byte index to 0;
    - advance channel, wrapping from NUM_CHANNELS-1 to 0.
- Timeout:
  - An idle counter runs in IDLE while byte index != 0 and clears on every falling edge.
  - At TIMEOUT_BITS bit periods it clears byte index and channel to 0. No error pulse.
  - Channel is not cleared by timeout if byte index = 0.
- Latency: VALID_o and head data update on the clock edge after the good stop-bit sampling edge, if the FIFO was empty.
- FIFO:
  - Show-ahead: SAMPLE_o/CHANNEL_o are valid whenever VALID_o=1.
  - Pop on VALID_o & READY_i.
  - Push when full without a simultaneous pop drops the new sample, keeps existing entries, and pulses OVERFLOW_o.
  - Push and pop in the same cycle when full both succeed; count is unchanged.
  - Push and pop in the same cycle when count = 1 keeps VALID_o high, with the head advancing to the new entry.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs are held stable while VALID_o=1 and READY_i=0.

Optional Feature:
- UART_PARITY_EN defined:
  - DATA is followed by an even-parity bit, sampled at its centre, before STOP.
  - Parity mismatch is handled exactly as a framing error: FRAME_ERR_o pulse, clear, then WAIT_HIGH when the line is low, otherwise IDLE.
- UART_PARITY_EN undefined: 8N1 framing only; there is no parity state.

Test Plan:
- Defaults, READY_i=1, bytes 0x00 then 0x40 at 52 clocks/bit -> one VALID_o cycle with SAMPLE_o=16'h4000, CHANNEL_o=0, the edge after the stop centre.
- NUM_CHANNELS=2, bytes 0x00,0x61,0x03,0x90 -> 16'h6100 on ch0 then 16'h9003 on ch1; next sample is ch0.
- Byte 0x29 with stop bit forced 0, line high, then 0x09,0x40 -> FRAME_ERR_o single pulse, no output for 0x29, then 16'h4009 ch0.
- Byte 0x77, idle 25 bit periods, then 0x19,0x91 -> exactly one sample, 16'h9119 ch0.
- READY_i=0, five samples 1..5, FIFO_DEPTH=4 -> one OVERFLOW_o pulse during sample 5. Raising READY_i yields 1,2,3,4, then VALID_o=0.
- RST_N_i low for 3 clocks during bit 4 of the first byte, then a full 0x00,0x40 frame -> all outputs 0 during reset, then only 16'h4000 emitted.
- With UART_PARITY_EN: 0x03 with bad parity -> FRAME_ERR_o pulse and no sample.
